pal_dma_ctrl: RTL and testbench

- Sequencer that copies a block of palette words from main/work RAM into the 8K×16 palette RAM.
- Drives the palette RAM's DMA-side interface (ga21_addr/ga21_we/ga21_req, dma_busy), which takes priority over CPU and pixel lookups while a copy runs.
- Sits between the CPU DMA-register decode and the palette RAM; owns the read handshake to the memory arbiter.

---
 rtl/pal_dma_pkg.sv | 14 +
 rtl/pal_dma_ctrl.sv | 130 +++++++++++++
 tb/tb_pal_dma_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pal_dma_pkg.sv
// Shared types for the palette DMA sequencer: FSM encoding and palette depth.
package pal_dma_pkg;

  localparam int PAL_WORDS = 8192;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VBL,
    READ,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/pal_dma_ctrl.sv
// Copies count words from source memory into palette RAM, 2+ cycles/word (READ then WRITE).
// Holds the read request and the palette bus claim for as long as mem_ack is stalled; starts while busy are dropped.
module pal_dma_ctrl
  import pal_dma_pkg::*;
#(
  parameter int DST_AW = 13,
  parameter int SRC_AW = 20,
  parameter int LEN_W  = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SRC_AW-1:0] src_base,
  input  logic [DST_AW-1:0] dst_base,
  input  logic [LEN_W-1:0]  count,
  input  logic              wait_vblank,
  input  logic              vblank,
  output logic              mem_req,
  output logic [SRC_AW-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_data,
  output logic              ga21_req,
  output logic              ga21_we,
  output logic [DST_AW-1:0] ga21_addr,
  output logic [15:0]       ga21_data,
  output logic              dma_busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic              vblank_q;
  logic [SRC_AW-1:0] src_q, src_d;
  logic [DST_AW-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [15:0]       data_q, data_d;
  logic              mem_req_q, mem_req_d;
  logic              ga21_req_q, ga21_req_d;
  logic              ga21_we_q, ga21_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              vbl_rise;

  assign vbl_rise = vblank & ~vblank_q;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            src_d   = src_base;
            dst_d   = dst_base;
            rem_d   = count;
            state_d = wait_vblank ? WAIT_VBL : READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      WAIT_VBL: if (vbl_rise) state_d = READ;
      READ: begin
        if (mem_ack) begin
          data_d  = mem_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        src_d = src_q + SRC_AW'(1);
        dst_d = DST_AW'((int'(dst_q) + 1) % PAL_WORDS);
        rem_d = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so every port comes straight off a flop.
    mem_req_d  = (state_d == READ);
    ga21_req_d = (state_d == READ) || (state_d == WRITE);
    ga21_we_d  = (state_d == WRITE);
    busy_d     = (state_d == WAIT_VBL) || (state_d == READ) || (state_d == WRITE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      vblank_q   <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
      rem_q      <= '0;
      data_q     <= '0;
      mem_req_q  <= 1'b0;
      ga21_req_q <= 1'b0;
      ga21_we_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vblank_q   <= vblank;
      src_q      <= src_d;
      dst_q      <= dst_d;
      rem_q      <= rem_d;
      data_q     <= data_d;
      mem_req_q  <= mem_req_d;
      ga21_req_q <= ga21_req_d;
      ga21_we_q  <= ga21_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = src_q;
  assign ga21_req  = ga21_req_q;
  assign ga21_we   = ga21_we_q;
  assign ga21_addr = dst_q;
  assign ga21_data = data_q;
  assign dma_busy  = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pal_dma_ctrl.sv
// Bench for pal_dma_ctrl: a latency-programmable source memory, a bus monitor, and an
// expected-write list built from base + index arithmetic with palette/source wrap.
module tb_pal_dma_ctrl;

  localparam int PALW = 8192;
  localparam int SRCW = 1 << 20;

  logic        clk, reset, start, wait_vblank, vblank;
  logic [19:0] src_base, mem_addr;
  logic [12:0] dst_base, ga21_addr;
  logic [13:0] count;
  logic        mem_req, mem_ack, ga21_req, ga21_we, dma_busy, done;
  logic [15:0] mem_data, ga21_data;

  int          checks, errors;
  int          ack_delay;
  logic [15:0] salt;

  pal_dma_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .src_base(src_base), .dst_base(dst_base),
    .count(count), .wait_vblank(wait_vblank), .vblank(vblank), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data), .ga21_req(ga21_req),
    .ga21_we(ga21_we), .ga21_addr(ga21_addr), .ga21_data(ga21_data),
    .dma_busy(dma_busy), .done(done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] memf(input logic [19:0] a);
    return a[15:0] ^ {a[19:16], a[3:0], 8'h5A} ^ salt;
  endfunction

  // Source memory: acks ack_delay cycles after it first sees mem_req.
  int wcnt;
  initial begin
    mem_ack = 0; mem_data = 0; wcnt = 0;
    forever begin
      @(posedge clk or posedge reset);
      #1;
      if (reset || !mem_req) begin
        mem_ack = 0; wcnt = 0;
      end else if (!mem_ack) begin
        if (wcnt >= ack_delay) begin
          mem_ack = 1; mem_data = memf(mem_addr);
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Bus monitor, sampled mid-cycle.
  logic [12:0] wa[$];
  logic [15:0] wd[$];
  int          done_n, req_n, busy_n, greq_n, rise_n, viol_n;
  logic        greq_prev, ack_prev, req_prev;
  logic [19:0] addr_prev;
  initial begin
    done_n = 0; req_n = 0; busy_n = 0; greq_n = 0; rise_n = 0; viol_n = 0;
    greq_prev = 0; ack_prev = 0; req_prev = 0; addr_prev = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        greq_prev = 0; ack_prev = 0; req_prev = 0;
      end else begin
        if (ga21_we) begin
          wa.push_back(ga21_addr); wd.push_back(ga21_data);
          if (!ack_prev || !ga21_req || mem_req) viol_n++;
        end
        if (done) done_n++;
        if (mem_req) req_n++;
        if (dma_busy) busy_n++;
        if (ga21_req) greq_n++;
        if (ga21_req && !greq_prev) rise_n++;
        if (mem_req && req_prev && !ack_prev && mem_addr !== addr_prev) viol_n++;
        if (done && (dma_busy || ga21_req)) viol_n++;
        if (mem_req && !ga21_req) viol_n++;
        greq_prev = ga21_req; ack_prev = mem_ack; req_prev = mem_req; addr_prev = mem_addr;
      end
    end
  end

  typedef struct {int wr, dn, rq, bz, gq, rs, vi;} snap_t;
  function automatic snap_t snap();
    snap_t s;
    s.wr = wa.size(); s.dn = done_n; s.rq = req_n; s.bz = busy_n;
    s.gq = greq_n; s.rs = rise_n; s.vi = viol_n;
    return s;
  endfunction

  task automatic issue_start(input logic [19:0] s, input logic [12:0] d, input logic [13:0] c,
                             input bit wv);
    @(negedge clk);
    start = 1; src_base = s; dst_base = d; count = c; wait_vblank = wv;
    @(negedge clk);
    start = 0; src_base = 20'($urandom); dst_base = 13'($urandom); count = 14'($urandom);
    wait_vblank = 1'($urandom);
  endtask

  task automatic wait_done(output bit to);
    int base;
    base = done_n;
    to = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #2;
      if (done_n > base) begin to = 0; break; end
    end
    repeat (3) @(negedge clk);
    #2;
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(negedge clk);
    checks++; if ({mem_req, ga21_req, ga21_we, dma_busy, done} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=00000", {mem_req, ga21_req, ga21_we, dma_busy, done}); end
    checks++; if (mem_addr !== 20'h0) begin
      errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (ga21_addr !== 13'h0) begin
      errors++; $display("FAIL reset_ga21_addr got=%h exp=0", ga21_addr); end
    checks++; if (ga21_data !== 16'h0) begin
      errors++; $display("FAIL reset_ga21_data got=%h exp=0", ga21_data); end
    reset = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_copy(input string name, input logic [19:0] s, input logic [12:0] d,
                           input int c, input int dly, input bit mid);
    snap_t b;
    bit    to;
    int    ea, es;
    b = snap();
    ack_delay = dly;
    issue_start(s, d, 14'(c), 0);
    if (mid) begin
      @(negedge clk);
      start = 1; src_base = ~s; dst_base = ~d; count = 14'd5; wait_vblank = 0;
      @(negedge clk);
      start = 0;
    end
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL %s timeout got=no_done exp=done", name); end
    checks++; if (wa.size() - b.wr !== c) begin
      errors++; $display("FAIL %s write_count got=%0d exp=%0d", name, wa.size() - b.wr, c); end
    for (int i = 0; i < c; i++) begin
      ea = (int'(d) + i) % PALW;
      es = (int'(s) + i) % SRCW;
      checks++;
      if (b.wr + i >= wa.size()) begin
        errors++; $display("FAIL %s write%0d got=missing exp=%h/%h", name, i, ea, memf(20'(es)));
      end else if (wa[b.wr+i] !== 13'(ea) || wd[b.wr+i] !== memf(20'(es))) begin
        errors++; $display("FAIL %s write%0d got=%h/%h exp=%h/%h", name, i,
                           wa[b.wr+i], wd[b.wr+i], ea, memf(20'(es)));
      end
    end
    checks++; if (done_n - b.dn !== 1) begin
      errors++; $display("FAIL %s done_pulses got=%0d exp=1", name, done_n - b.dn); end
    checks++; if (busy_n - b.bz !== c * (dly + 2)) begin
      errors++; $display("FAIL %s busy_cycles got=%0d exp=%0d", name, busy_n - b.bz, c * (dly + 2)); end
    checks++; if (greq_n - b.gq !== c * (dly + 2) || rise_n - b.rs !== 1) begin
      errors++; $display("FAIL %s ga21_req cycles/rises got=%0d/%0d exp=%0d/1", name,
                         greq_n - b.gq, rise_n - b.rs, c * (dly + 2)); end
    checks++; if (req_n - b.rq !== c * (dly + 1)) begin
      errors++; $display("FAIL %s mem_req_cycles got=%0d exp=%0d", name, req_n - b.rq, c * (dly + 1)); end
    checks++; if (viol_n - b.vi !== 0) begin
      errors++; $display("FAIL %s protocol_violations got=%0d exp=0", name, viol_n - b.vi); end
  endtask

  task automatic test_vblank;
    snap_t b;
    bit    to;
    logic [19:0] s;
    logic [12:0] d;
    s = 20'($urandom); d = 13'($urandom);
    vblank = 1;
    repeat (2) @(negedge clk);
    b = snap();
    ack_delay = 1;
    issue_start(s, d, 14'd3, 1);
    repeat (5) @(negedge clk);
    #2;
    checks++; if (req_n - b.rq !== 0 || dma_busy !== 1'b1 || ga21_req !== 1'b0) begin
      errors++; $display("FAIL vbl_held got req=%0d busy=%b greq=%b exp req=0 busy=1 greq=0",
                         req_n - b.rq, dma_busy, ga21_req); end
    vblank = 0;
    repeat (4) @(negedge clk);
    #2;
    checks++; if (req_n - b.rq !== 0 || dma_busy !== 1'b1) begin
      errors++; $display("FAIL vbl_fall got req=%0d busy=%b exp req=0 busy=1", req_n - b.rq, dma_busy); end
    vblank = 1;
    repeat (3) @(negedge clk);
    vblank = 0;
    wait_done(to);
    checks++; if (to || wa.size() - b.wr !== 3) begin
      errors++; $display("FAIL vbl_copy got writes=%0d timeout=%b exp writes=3 timeout=0",
                         wa.size() - b.wr, to); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (b.wr + i >= wa.size() || wa[b.wr+i] !== 13'((int'(d) + i) % PALW) ||
          wd[b.wr+i] !== memf(20'((int'(s) + i) % SRCW))) begin
        errors++; $display("FAIL vbl_write%0d got=%h exp=%h", i,
                           (b.wr + i < wa.size()) ? wa[b.wr+i] : 13'h0, 13'((int'(d) + i) % PALW));
      end
    end
    checks++; if (done_n - b.dn !== 1 || viol_n - b.vi !== 0) begin
      errors++; $display("FAIL vbl_done got done=%0d viol=%0d exp done=1 viol=0",
                         done_n - b.dn, viol_n - b.vi); end
  endtask

  task automatic test_zero_len;
    snap_t b;
    b = snap();
    issue_start(20'($urandom), 13'($urandom), 14'd0, 1'($urandom));
    checks++; if (done !== 1'b1 || dma_busy !== 1'b0) begin
      errors++; $display("FAIL zero_done_next got done=%b busy=%b exp done=1 busy=0", done, dma_busy); end
    repeat (4) @(negedge clk);
    #2;
    checks++; if (done_n - b.dn !== 1 || req_n - b.rq !== 0 || busy_n - b.bz !== 0 || wa.size() !== b.wr) begin
      errors++; $display("FAIL zero_len got done=%0d req=%0d busy=%0d wr=%0d exp 1/0/0/0",
                         done_n - b.dn, req_n - b.rq, busy_n - b.bz, wa.size() - b.wr); end
  endtask

  task automatic test_reset_mid;
    snap_t b;
    b = snap();
    ack_delay = 1;
    issue_start(20'h2_0000, 13'h0800, 14'd8, 0);
    for (int i = 0; i < 200 && (wa.size() - b.wr) < 2; i++) begin
      @(negedge clk); #2;
    end
    checks++; if (wa.size() - b.wr !== 2) begin
      errors++; $display("FAIL rst_mid_reach got writes=%0d exp=2", wa.size() - b.wr); end
    reset = 1;
    #1;
    checks++; if ({mem_req, ga21_req, ga21_we, dma_busy, done, mem_addr, ga21_addr, ga21_data} !== '0) begin
      errors++; $display("FAIL rst_mid_async got req=%b greq=%b we=%b busy=%b done=%b exp all 0",
                         mem_req, ga21_req, ga21_we, dma_busy, done); end
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (6) @(negedge clk);
    #2;
    checks++; if (done_n - b.dn !== 0 || wa.size() - b.wr !== 2 || dma_busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_abort got done=%0d writes=%0d busy=%b exp 0/2/0",
                         done_n - b.dn, wa.size() - b.wr, dma_busy); end
  endtask

  task automatic test_random;
    for (int k = 0; k < 6; k++) begin
      test_copy("random", 20'($urandom), 13'($urandom), int'($urandom_range(1, 6)),
                int'($urandom_range(0, 3)), 1'(k % 2));
    end
  endtask

  initial begin
    checks = 0; errors = 0; ack_delay = 0;
    salt = 16'($urandom);
    reset = 1; start = 0; src_base = 0; dst_base = 0; count = 0;
    wait_vblank = 0; vblank = 0;
    test_reset();
    test_copy("immediate", 20'h01000, 13'h0100, 4, 0, 1);
    test_vblank();
    test_copy("wrap", 20'hFFFFE, 13'h1FFE, 4, 0, 0);
    test_zero_len();
    test_copy("stall", 20'h0ABCD, 13'h0040, 3, 5, 0);
    test_reset_mid();
    test_copy("after_reset", 20'h03000, 13'h0200, 5, 1, 0);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
